// File: rtl/controller_pkg.sv
// ----------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the controller poll scheduler:
//   poll_state_t  - poll sequencer states
//   ADDR_STATUS   - CPU address of the status register
//   STAT_*        - bit positions inside the status register
// ----------------------------------------------------------------------------
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        REQ     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4
    } poll_state_t;

    localparam logic [3:0] ADDR_STATUS = 4'hF;

    // Status register layout: {enable, 4'b0, overrun, busy, new_data}
    localparam int STAT_NEW_DATA = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_ENABLE   = 7;

endpackage

// File: rtl/controller_poll_scheduler_if.sv
// ----------------------------------------------------------------------------
// controller_poll_scheduler_if
// CPU register-read bus between the bus decoder (master) and the poll
// scheduler (slave).
//   cpu_addr_i  - 4-bit register address
//   cpu_rd_i    - single-cycle read strobe
//   cpu_rdata_o - registered read data
//
// Handshake: there is no backpressure. A read is issued by holding cpu_rd_i
// high for exactly one clk with cpu_addr_i valid in the same cycle; the slave
// always accepts it. cpu_rdata_o carries the addressed register, as it was
// before that edge, from the following clk onward and holds until the next
// read. Read side effects (read-to-clear) take effect on the accepting edge.
// ----------------------------------------------------------------------------
interface controller_poll_scheduler_if;

    logic [3:0] cpu_addr_i;
    logic       cpu_rd_i;
    logic [7:0] cpu_rdata_o;

    modport master (
        output cpu_addr_i,
        output cpu_rd_i,
        input  cpu_rdata_o
    );

    modport slave (
        input  cpu_addr_i,
        input  cpu_rd_i,
        output cpu_rdata_o
    );

endinterface

// File: rtl/controller_edge_tracker.sv
// ----------------------------------------------------------------------------
// controller_edge_tracker
// Per-controller button history with sticky "newly pressed" flags.
//   clk, rst       - system clock, synchronous active-high reset
//   capture        - one-cycle strobe: snapshot data into cur, cur into prev
//   clear_pressed  - one-cycle strobe: CPU read of the pressed register
//   data           - deserialized active-high buttons for this controller
//   cur            - buttons from the latest capture
//   prev           - buttons from the capture before that
//   pressed        - sticky rising-edge flags since the last CPU read
// ----------------------------------------------------------------------------
module controller_edge_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic       clear_pressed,
    input  logic [7:0] data,
    output logic [7:0] cur,
    output logic [7:0] prev,
    output logic [7:0] pressed
);

    // Buttons that are down now but were up at the previous capture.
    logic [7:0] newly_set;

    assign newly_set = data & ~cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '0;
            prev    <= '0;
            pressed <= '0;
        end else begin
            if (capture) begin
                prev <= cur;
                cur  <= data;
            end

            // A read that lands on a capture edge drops the bits the CPU
            // just saw but keeps the edges arriving on that same edge, so no
            // press is ever lost between two reads.
            if (capture && clear_pressed) begin
                pressed <= newly_set;
            end else if (capture) begin
                pressed <= pressed | newly_set;
            end else if (clear_pressed) begin
                pressed <= '0;
            end
        end
    end

endmodule

// File: rtl/controller_poll_scheduler.sv
// ----------------------------------------------------------------------------
// controller_poll_scheduler
// Once per frame, requests a fetch from the serial controller shift
// interface, waits a settle window counted in serial ticks, then snapshots
// the deserialized buttons and raises a level interrupt for the CPU.
//
// Parameters:
//   NUM_CONTROLLERS - controller ports, 1..4
//   SETTLE_TICKS    - serial ticks between end of request and sampling, >= 13
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   enable_i        - polling enabled; low blocks new polls only
//   vblank_i        - one-cycle start-of-vblank pulse, triggers a poll
//   ser_tick_i      - one-cycle pulse per serial-interface clock period
//   start_fetch_o   - fetch request to the shift interface (one tick period)
//   data_list_i     - NUM_CONTROLLERS x 8 active-high buttons, controller k
//                     at bits [8k+7:8k]
//   cpu             - register read bus (slave side)
//   busy_o          - poll in progress
//   irq_o           - high while the new-data flag is set
//   dbg_state_o     - current sequencer state
//   dbg_prev_o      - previous snapshot per controller
//
// Register map: 2k = cur[k], 2k+1 = pressed[k] (read-to-clear),
// 0xF = status (read clears new_data and overrun), others read 0x00.
// ----------------------------------------------------------------------------
module controller_poll_scheduler
    import controller_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int SETTLE_TICKS    = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic                         vblank_i,
    input  logic                         ser_tick_i,
    output logic                         start_fetch_o,
    input  logic [NUM_CONTROLLERS*8-1:0] data_list_i,
    controller_poll_scheduler_if.slave   cpu,
    output logic                         busy_o,
    output logic                         irq_o,
    output poll_state_t                  dbg_state_o,
    output logic [NUM_CONTROLLERS*8-1:0] dbg_prev_o
);

    localparam int              CNT_W       = $clog2(SETTLE_TICKS + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_TICKS);

    poll_state_t          state;
    poll_state_t          state_nxt;
    logic [CNT_W-1:0]     tick_cnt;

    logic                 capture;
    logic                 overrun_set;
    logic                 status_rd;
    logic                 new_data;
    logic                 overrun;

    logic [NUM_CONTROLLERS-1:0] clear_pressed;
    logic [7:0]           cur     [NUM_CONTROLLERS];
    logic [7:0]           pressed [NUM_CONTROLLERS];

    logic [7:0]           status;
    logic [7:0]           rd_data;

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (vblank_i && enable_i) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (ser_tick_i) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ser_tick_i) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tick_cnt == '0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: outputs
    // ------------------------------------------------------------------
    // The request is REQ decoded directly, so it spans exactly the serial
    // period between the ARM tick and the next tick. Gating with rst lets
    // a reset pull the request down before the reset edge arrives.
    always_comb begin
        start_fetch_o = (state == REQ) && !rst;
        busy_o        = (state != IDLE);
        capture       = (state == CAPTURE);
    end

    assign dbg_state_o = state;

    // ------------------------------------------------------------------
    // Settle counter: loaded on the tick that ends REQ, counts ticks down
    // and parks at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if ((state == REQ) && ser_tick_i) begin
            tick_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && ser_tick_i && (tick_cnt != '0)) begin
            tick_cnt <= tick_cnt - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Status flags. A set on the same edge as a status read wins, so an
    // event arriving while the CPU reads is reported on the next read.
    // ------------------------------------------------------------------
    assign overrun_set = vblank_i && (state != IDLE);
    assign status_rd   = cpu.cpu_rd_i && (cpu.cpu_addr_i == ADDR_STATUS);

    always_ff @(posedge clk) begin
        if (rst) begin
            new_data <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (capture) begin
                new_data <= 1'b1;
            end else if (status_rd) begin
                new_data <= 1'b0;
            end

            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (status_rd) begin
                overrun <= 1'b0;
            end
        end
    end

    assign irq_o = new_data;

    // ------------------------------------------------------------------
    // Per-controller button trackers
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_ctrl
        assign clear_pressed[k] = cpu.cpu_rd_i && (cpu.cpu_addr_i == 4'(2*k + 1));

        controller_edge_tracker u_tracker (
            .clk           (clk),
            .rst           (rst),
            .capture       (capture),
            .clear_pressed (clear_pressed[k]),
            .data          (data_list_i[k*8 +: 8]),
            .cur           (cur[k]),
            .prev          (dbg_prev_o[k*8 +: 8]),
            .pressed       (pressed[k])
        );
    end

    // ------------------------------------------------------------------
    // Read path. The mux sees register contents before the current edge,
    // so a read coinciding with CAPTURE returns the old snapshot.
    // ------------------------------------------------------------------
    always_comb begin
        status                = '0;
        status[STAT_ENABLE]   = enable_i;
        status[STAT_OVERRUN]  = overrun;
        status[STAT_BUSY]     = busy_o;
        status[STAT_NEW_DATA] = new_data;

        rd_data = '0;
        if (cpu.cpu_addr_i == ADDR_STATUS) begin
            rd_data = status;
        end else begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                if (cpu.cpu_addr_i == 4'(2*k)) begin
                    rd_data = cur[k];
                end
                if (cpu.cpu_addr_i == 4'(2*k + 1)) begin
                    rd_data = pressed[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.cpu_rdata_o <= '0;
        end else if (cpu.cpu_rd_i) begin
            cpu.cpu_rdata_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// ----------------------------------------------------------------------------
// tb_controller_poll_scheduler
// Self-checking bench for controller_poll_scheduler. A behavioural model of
// the CPU-visible registers (cur/prev/pressed arrays, new_data, overrun) is
// updated at each poll and each read; every CPU read and key output is
// compared against it.
// ----------------------------------------------------------------------------
module tb_controller_poll_scheduler;
    import controller_pkg::*;

    localparam int NC       = 2;
    localparam int ST       = 14;
    localparam int TICK_DIV = 4;
    localparam int LAT_MAX  = (ST + 2) * TICK_DIV + 2;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable_i = 1'b0;
    logic            vblank_i = 1'b0;
    logic            ser_tick_i = 1'b0;
    logic [NC*8-1:0] data_list_i = '0;
    logic            start_fetch_o;
    logic            busy_o;
    logic            irq_o;
    poll_state_t     dbg_state_o;
    logic [NC*8-1:0] dbg_prev_o;

    controller_poll_scheduler_if cpu ();

    controller_poll_scheduler #(
        .NUM_CONTROLLERS (NC),
        .SETTLE_TICKS    (ST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .vblank_i      (vblank_i),
        .ser_tick_i    (ser_tick_i),
        .start_fetch_o (start_fetch_o),
        .data_list_i   (data_list_i),
        .cpu           (cpu),
        .busy_o        (busy_o),
        .irq_o         (irq_o),
        .dbg_state_o   (dbg_state_o),
        .dbg_prev_o    (dbg_prev_o)
    );

    always #5 clk = ~clk;

    // Serial tick: one clk-wide pulse every TICK_DIV clocks.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ser_tick_i = (ph == TICK_DIV - 1);
            ph = (ph + 1) % TICK_DIV;
        end
    end

    // ---------------- scoreboard / model ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_m     [NC];
    logic [7:0] prev_m    [NC];
    logic [7:0] pressed_m [NC];
    bit         new_data_m;
    bit         overrun_m;

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) begin
            cur_m[k] = 8'h00; prev_m[k] = 8'h00; pressed_m[k] = 8'h00;
        end
        new_data_m = 1'b0;
        overrun_m  = 1'b0;
    endfunction

    function automatic void model_capture(input logic [NC*8-1:0] d);
        for (int k = 0; k < NC; k++) begin
            pressed_m[k] = pressed_m[k] | (d[k*8 +: 8] & ~cur_m[k]);
            prev_m[k]    = cur_m[k];
            cur_m[k]     = d[k*8 +: 8];
        end
        new_data_m = 1'b1;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a, input bit busy_now);
        logic [7:0] r;
        int idx;
        r = 8'h00;
        idx = int'(a) / 2;
        if (a == 4'hF) begin
            r[7] = enable_i; r[2] = overrun_m; r[1] = busy_now; r[0] = new_data_m;
        end else if (int'(a) < 2 * NC) begin
            r = a[0] ? pressed_m[idx] : cur_m[idx];
        end
        return r;
    endfunction

    function automatic void model_clear(input logic [3:0] a);
        if (a == 4'hF) begin
            new_data_m = 1'b0;
            overrun_m  = 1'b0;
        end else if ((int'(a) < 2 * NC) && a[0]) begin
            pressed_m[int'(a) / 2] = 8'h00;
        end
    endfunction

    function automatic logic [NC*8-1:0] rand_data();
        logic [NC*8-1:0] d;
        for (int k = 0; k < NC; k++) d[k*8 +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        cpu.cpu_addr_i = a;
        cpu.cpu_rd_i   = 1'b1;
        @(posedge clk); #1;
        cpu.cpu_rd_i   = 1'b0;
        d = cpu.cpu_rdata_o;
    endtask

    task automatic pulse_vblank();
        @(posedge clk); #1;
        vblank_i = 1'b1;
        @(posedge clk); #1;
        vblank_i = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (busy_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_poll(input logic [NC*8-1:0] d);
        bit ok;
        data_list_i = d;
        enable_i    = 1'b1;
        pulse_vblank();
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL poll_busy_rise got=%b exp=1", busy_o);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL poll_timeout got=busy exp=idle");
        end
        model_capture(d);
    endtask

    // Starts a poll and issues a CPU read in the CAPTURE cycle.
    task automatic collide_poll(input logic [NC*8-1:0] d, input logic [3:0] a,
                                output logic [7:0] got, output logic [7:0] exp, output bit ok);
        data_list_i = d;
        enable_i    = 1'b1;
        pulse_vblank();
        enable_i    = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (dbg_state_o == CAPTURE) begin
                ok = 1'b1;
                break;
            end
        end
        exp = model_read(a, 1'b1);
        model_clear(a);
        model_capture(d);
        cpu.cpu_addr_i = a;
        cpu.cpu_rd_i   = 1'b1;
        @(posedge clk); #1;
        cpu.cpu_rd_i   = 1'b0;
        got = cpu.cpu_rdata_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] got, exp;
        int fetch_hits, busy_hits;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if ({start_fetch_o, busy_o, irq_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs got=%b exp=000", {start_fetch_o, busy_o, irq_o});
        end
        n_checks++;
        if (cpu.cpu_rdata_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata got=%h exp=00", cpu.cpu_rdata_o);
        end
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            exp = model_read(4'(a), 1'b0); model_clear(4'(a));
            cpu_read(4'(a), got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL reset_read addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        enable_i = 1'b1;
        fetch_hits = 0; busy_hits = 0;
        repeat (100 * TICK_DIV) begin
            @(negedge clk);
            if (start_fetch_o !== 1'b0) fetch_hits++;
            if (busy_o !== 1'b0) busy_hits++;
        end
        n_checks++;
        if (fetch_hits != 0 || busy_hits != 0) begin
            n_fail++; $display("FAIL idle_no_fetch got=%0d/%0d exp=0/0", fetch_hits, busy_hits);
        end
    endtask

    task automatic test_single_poll();
        logic [NC*8-1:0] d;
        logic [7:0] got, exp;
        int sf_cyc, settle_ticks, lat;
        bit fetch_seen, fetch_done, got_irq;
        d = rand_data();
        d[7:0] = 8'h81;
        data_list_i = d;
        enable_i = 1'b1;
        pulse_vblank();
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_rise got=%b exp=1", busy_o);
        end
        enable_i = 1'b0;    // poll already accepted must still finish
        sf_cyc = 0; settle_ticks = 0; lat = -1;
        fetch_seen = 0; fetch_done = 0; got_irq = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (irq_o === 1'b1) begin
                got_irq = 1; lat = c;
                break;
            end
            if (start_fetch_o === 1'b1) begin
                fetch_seen = 1; sf_cyc++;
            end else if (fetch_seen) begin
                fetch_done = 1;
            end
            if (fetch_done && ser_tick_i) settle_ticks++;
        end
        model_capture(d);
        n_checks++;
        if (!got_irq) begin
            n_fail++; $display("FAIL single_irq_timeout got=0 exp=1");
        end
        n_checks++;
        if (sf_cyc != TICK_DIV) begin
            n_fail++; $display("FAIL single_fetch_width got=%0d exp=%0d", sf_cyc, TICK_DIV);
        end
        n_checks++;
        if (settle_ticks != ST) begin
            n_fail++; $display("FAIL single_settle_ticks got=%0d exp=%0d", settle_ticks, ST);
        end
        n_checks++;
        if (lat < 0 || lat > LAT_MAX) begin
            n_fail++; $display("FAIL single_latency got=%0d exp<=%0d", lat, LAT_MAX);
        end
        for (int a = 0; a < 2 * NC; a += 2) begin
            exp = model_read(4'(a), 1'b0); model_clear(4'(a));
            cpu_read(4'(a), got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL single_cur addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        for (int r = 0; r < 2; r++) begin
            exp = model_read(4'hF, 1'b0); model_clear(4'hF);
            cpu_read(4'hF, got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL single_status%0d got=%h exp=%h", r, got, exp);
            end
            n_checks++;
            if (irq_o !== new_data_m) begin
                n_fail++; $display("FAIL single_irq%0d got=%b exp=%b", r, irq_o, new_data_m);
            end
        end
    endtask

    task automatic test_edge_detect();
        logic [NC*8-1:0] d;
        logic [7:0] got, exp;
        d = rand_data();
        d[7:0] = 8'h83;
        run_poll(d);
        n_checks++;
        if (dbg_prev_o[7:0] !== prev_m[0]) begin
            n_fail++; $display("FAIL edge_prev0 got=%h exp=%h", dbg_prev_o[7:0], prev_m[0]);
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NC; k++) begin
                exp = model_read(4'(2*k + 1), 1'b0); model_clear(4'(2*k + 1));
                cpu_read(4'(2*k + 1), got);
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL edge_pressed%0d_rd%0d got=%h exp=%h", k, r, got, exp);
                end
            end
        end
        exp = model_read(4'hF, 1'b0); model_clear(4'hF);
        cpu_read(4'hF, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL edge_status got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_collision();
        logic [NC*8-1:0] d;
        logic [7:0] got, exp;
        bit ok;
        d = '0; run_poll(d);
        d[7:0] = 8'h01; run_poll(d);
        d[7:0] = 8'h00; run_poll(d);
        // pressed0 holds 0x01; read it on the CAPTURE edge of a 0x00->0x10 poll
        d[7:0] = 8'h10;
        collide_poll(d, 4'h1, got, exp, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL collide_pressed_timeout got=0 exp=1");
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL collide_pressed_old got=%h exp=%h", got, exp);
        end
        exp = model_read(4'h1, 1'b0); model_clear(4'h1);
        cpu_read(4'h1, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL collide_pressed_after got=%h exp=%h", got, exp);
        end
        // status read on the CAPTURE edge: new_data must survive
        collide_poll(rand_data(), 4'hF, got, exp, ok);
        n_checks++;
        if (!ok || got !== exp) begin
            n_fail++; $display("FAIL collide_status got=%h exp=%h ok=%b", got, exp, ok);
        end
        #1;
        n_checks++;
        if (irq_o !== 1'b1) begin
            n_fail++; $display("FAIL collide_irq_kept got=%b exp=1", irq_o);
        end
    endtask

    task automatic test_overrun();
        logic [NC*8-1:0] d;
        logic [7:0] got, exp;
        bit seen, done, ok;
        int busy_hits;
        d = rand_data();
        data_list_i = d;
        enable_i = 1'b1;
        pulse_vblank();
        enable_i = 1'b0;
        seen = 0; done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (start_fetch_o === 1'b1) seen = 1;
            else if (seen) done = 1;
        end
        repeat (3 * TICK_DIV) @(posedge clk);
        pulse_vblank();     // lands in the settle window
        overrun_m = 1'b1;
        n_checks++;
        if (!done || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL overrun_poll_running got=%b exp=1", busy_o);
        end
        wait_idle(ok);
        model_capture(d);
        n_checks++;
        if (!ok || irq_o !== 1'b1) begin
            n_fail++; $display("FAIL overrun_poll_done got=%b exp=1", irq_o);
        end
        for (int a = 0; a < 2 * NC; a++) begin
            exp = model_read(4'(a), 1'b0); model_clear(4'(a));
            cpu_read(4'(a), got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL overrun_data addr=%h got=%h exp=%h", a, got, exp);
            end
        end
        for (int r = 0; r < 2; r++) begin
            exp = model_read(4'hF, 1'b0); model_clear(4'hF);
            cpu_read(4'hF, got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL overrun_status%0d got=%h exp=%h", r, got, exp);
            end
        end
        busy_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_o !== 1'b0) busy_hits++;
        end
        n_checks++;
        if (busy_hits != 0) begin
            n_fail++; $display("FAIL overrun_dropped got=%0d exp=0", busy_hits);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [NC*8-1:0] d;
        logic [7:0] got, exp;
        bit seen;
        int hits;
        d = rand_data();
        d[7:0] = 8'hA5;
        run_poll(d);
        exp = model_read(4'h0, 1'b0);
        cpu_read(4'h0, got);
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL mid_req_preread got=%h exp=%h", got, exp);
        end
        pulse_vblank();
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (start_fetch_o === 1'b1) seen = 1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        n_checks++;
        if (!seen || {start_fetch_o, busy_o, irq_o} !== 3'b000) begin
            n_fail++; $display("FAIL mid_req_reset got=%b exp=000 seen=%b",
                               {start_fetch_o, busy_o, irq_o}, seen);
        end
        n_checks++;
        if (cpu.cpu_rdata_o !== 8'h00) begin
            n_fail++; $display("FAIL mid_req_rdata got=%h exp=00", cpu.cpu_rdata_o);
        end
        rst = 1'b0;
        enable_i = 1'b0;
        pulse_vblank();
        hits = 0;
        repeat (20 * TICK_DIV) begin
            @(negedge clk);
            if (start_fetch_o !== 1'b0 || busy_o !== 1'b0) hits++;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++; $display("FAIL disabled_no_fetch got=%0d exp=0", hits);
        end
        for (int a = 0; a < 16; a++) begin
            exp = model_read(4'(a), 1'b0); model_clear(4'(a));
            cpu_read(4'(a), got);
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL mid_req_regs addr=%h got=%h exp=%h", a, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        logic [3:0] a;
        for (int it = 0; it < 8; it++) begin
            run_poll(rand_data());
            enable_i = 1'($urandom_range(0, 1));
            for (int j = 0; j < 6; j++) begin
                a = 4'($urandom_range(0, 15));
                exp = model_read(a, 1'b0); model_clear(a);
                cpu_read(a, got);
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL random_read it=%0d addr=%h got=%h exp=%h", it, a, got, exp);
                end
            end
            n_checks++;
            if (irq_o !== new_data_m) begin
                n_fail++; $display("FAIL random_irq it=%0d got=%b exp=%b", it, irq_o, new_data_m);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        cpu.cpu_addr_i = 4'h0;
        cpu.cpu_rd_i   = 1'b0;
        model_reset();
        test_reset();
        test_single_poll();
        test_edge_detect();
        test_collision();
        test_overrun();
        test_reset_mid_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog got=running exp=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
